alu_operand_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 13 +
 rtl/alu_operand_sequencer.sv | 70 +++++++
 tb/tb_alu_operand_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM state encodings and ALU opcode constants
package alu_seq_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_B = 2'b01,
        EXEC   = 2'b10,
        OUT    = 2'b11
    } state_t;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;
endpackage

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects A then B, drives a sibling ALU, captures its result on a valid/ready output
// Optional result parity output when ALU_SEQ_PARITY_EN is defined.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [N-1:0]     alu_in0,
    output logic [N-1:0]     alu_in1,
    input  logic [N-1:0]     alu_out,
    output logic [N-1:0]     res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
`ifdef ALU_SEQ_PARITY_EN
    ,
    output logic             res_parity
`endif
);
    state_t state;
    logic   accept;
    assign din_ready = (state == IDLE) || (state == WAIT_B);
    assign busy      = state != IDLE;
    assign accept    = din_valid && din_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_in0   <= '0;
            alu_in1   <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            txn_count <= '0;
`ifdef ALU_SEQ_PARITY_EN
            res_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    alu_in0 <= din;
                    state   <= WAIT_B;
                end
                WAIT_B: if (accept) begin
                    alu_in1 <= din;
                    state   <= EXEC;
                end
                // ALU is combinational on the registered operands, so its result is ready here
                EXEC: begin
                    res       <= alu_out;
                    res_valid <= 1'b1;
`ifdef ALU_SEQ_PARITY_EN
                    res_parity <= ^alu_out;
`endif
                    state     <= OUT;
                end
                OUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    txn_count <= txn_count + CNT_W'(1);
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: randomized scoreboard bench for alu_operand_sequencer with a behavioural ALU beside it
module tb_alu_operand_sequencer;
    import alu_seq_pkg::*;
    localparam int N = 4;
    localparam int CNT_W = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_valid = 1'b0;
    logic res_ready = 1'b0;
    logic [N-1:0] din = '0;
    logic [N-1:0] alu_out, res, alu_in0, alu_in1;
    logic din_ready, res_valid, busy;
    logic [CNT_W-1:0] txn_count;
`ifdef ALU_SEQ_PARITY_EN
    logic res_parity;
`endif
    logic [1:0] op = OP_XOR;
    int rr_mode = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [N-1:0] alu_f(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        return o == OP_AND ? a & b : o == OP_OR ? a | b : o == OP_ADD ? N'(a + b) : a ^ b;
    endfunction

    assign alu_out = alu_f(op, alu_in0, alu_in1);

    alu_operand_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_out(alu_out),
        .res(res), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .txn_count(txn_count)
`ifdef ALU_SEQ_PARITY_EN
        , .res_parity(res_parity)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor: reference model of the transaction protocol, checked every cycle
    int n_ops = 0;
    bit outp = 1'b0;
    logic [N-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    initial forever begin
        @(negedge clk);
        chk("din_ready", din_ready, n_ops < 2 && !outp);
        chk("busy", busy, n_ops > 0 || outp);
        chk("res_valid", res_valid, outp);
        chk("res", res, m_res);
        chk("alu_in0", alu_in0, m_a);
        chk("alu_in1", alu_in1, m_b);
        chk("txn_count", txn_count, m_cnt);
`ifdef ALU_SEQ_PARITY_EN
        chk("res_parity", res_parity, ^m_res);
`endif
        if (rst) begin
            n_ops = 0; outp = 1'b0; m_a = '0; m_b = '0; m_res = '0; m_cnt = '0;
        end else if (outp) begin
            if (res_ready) begin
                outp = 1'b0;
                m_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL scoreboard_pop: got empty queue expected one entry");
                end else void'(exp_q.pop_front());
            end
        end else if (n_ops == 2) begin
            n_ops = 0;
            outp = 1'b1;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL scoreboard_peek: got empty queue expected one entry");
            end else m_res = exp_q[0];
        end else if (din_valid) begin
            if (n_ops == 0) m_a = din; else m_b = din;
            n_ops++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        res_ready = rr_mode == 0 ? 1'b1 : rr_mode == 2 ? 1'b0 : 1'($urandom);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [N-1:0] v, input int gap);
        int t = 0;
        repeat (gap) begin
            din_valid = 1'b0;
            din = N'($urandom);
            tick();
        end
        din = v;
        din_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!din_ready && t < 100);
        if (!din_ready) begin
            n_tests++; n_fail++;
            $display("FAIL put_timeout: got din_ready=0 expected 1 within 100 cycles");
        end
        tick();
        din_valid = 1'b0;
    endtask

    task automatic txn(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b, input int gap);
        put(a, gap);
        op = o;
        exp_q.push_back(alu_f(o, a, b));
        put(b, gap);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 200) begin
            tick();
            t++;
        end
        chk("idle_timeout", t < 200, 1);
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        put(4'hF, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rr_mode = 0;
        txn(OP_XOR, 4'b1010, 4'b0110, 0);
        wait_idle();
        rr_mode = 2;
        txn(OP_XOR, 4'b1010, 4'b0110, 0);
        repeat (6) begin
            din_valid = 1'($urandom);
            din = N'($urandom);
            tick();
        end
        din_valid = 1'b0;
        rr_mode = 0;
        wait_idle();
        txn(OP_ADD, 4'h3, 4'h9, 2);
        wait_idle();
        txn(OP_XOR, 4'b0001, 4'b0010, 0);
        txn(OP_XOR, 4'b0111, 4'b0000, 0);
        wait_idle();
        rr_mode = 2;
        txn(OP_OR, 4'h5, 4'hA, 1);
        repeat (3) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        rr_mode = 0;
        tick();
        rr_mode = 1;
        repeat (40) txn(2'($urandom), N'($urandom), N'($urandom), $urandom_range(0, 2));
        wait_idle();
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
